ts_packet_arbiter: RTL
======================

TS_PACKET_ARBITER -- requirements
Module: ts_packet_arbiter

Interface
REQ-001 SHALL have parameter PKT_LEN, default 188: TS packet length in bytes.
REQ-002 SHALL have parameter TIMEOUT, default 400: cycles to wait for the granted channel's packet start.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ts_in_1..ts_in_4  input  8 each  per-channel byte stream, one byte per clk, no gaps.
REQ-006 pkt_start_1..pkt_start_4  input  1 each  high in the same cycle as the 0x47 sync byte of a locked packet on the matching ts_in.
REQ-007 ch_enable  input  4  bit i-1 enables channel i for scheduling.
REQ-008 clear_lost  input  1  one-cycle pulse; clears lost flags.
REQ-009 ts_out  output  8  forwarded byte.
REQ-010 ts_valid  output  1  ts_out carries a packet byte.
REQ-011 ts_sop / ts_eop  output  1 each  first / last (PKT_LEN-th) byte of a forwarded packet.
REQ-012 ts_abort  output  1  one-cycle pulse; current packet truncated.
REQ-013 grant  output  2  index of the channel being served (0..3 = channels 1..4).
REQ-014 lost  output  4  sticky per-channel timeout flags.

Function
REQ-015 SHALL share the single output among 4 channels at packet granularity, round-robin, dropping non-granted channels' packets.
REQ-016 FSM states SHALL be SELECT, WAIT_START, FORWARD.
REQ-017 SELECT: if ch_enable==0, remain; else grant = first enabled channel after last_grant in cyclic order (wrapping 3->0), go to WAIT_START next cycle.
REQ-018 WAIT_START: on granted pkt_start -> FORWARD with the sync byte counted as byte 1; if TIMEOUT cycles elapse without it -> set lost[grant], advance last_grant, return to SELECT.
REQ-019 FORWARD: forward granted channel's bytes; byte counter 1..PKT_LEN; after byte PKT_LEN -> last_grant = grant, SELECT.
REQ-020 Output SHALL be registered: ts_out/ts_valid/ts_sop/ts_eop appear exactly 1 cycle after the input byte.
REQ-021 ts_sop SHALL accompany byte 1 (0x47), ts_eop byte PKT_LEN; exactly PKT_LEN ts_valid cycles per complete packet.
REQ-022 pkt_start on granted channel while FORWARD with counter < PKT_LEN SHALL: pulse ts_abort with the previous byte slot's successor cycle, deassert ts_valid for that byte, advance last_grant, go SELECT.
REQ-023 Deasserting the granted channel's ch_enable mid-FORWARD SHALL NOT truncate the packet; ch_enable is sampled only in SELECT and WAIT_START (disable in WAIT_START -> SELECT without setting lost).
REQ-024 pkt_start on non-granted channels SHALL be ignored.
REQ-025 clear_lost coinciding with a timeout on channel i SHALL leave lost[i] set (set wins).
REQ-026 Byte counter SHALL be ceil(log2(PKT_LEN+1)) bits; timeout counter ceil(log2(TIMEOUT+1)) bits; neither wraps.
REQ-027 grant SHALL hold stable from SELECT exit until return to SELECT.

Reset
REQ-028 On rst low: state SELECT, last_grant 3 (first grant = channel 1), counters 0, ts_out 0, ts_valid/ts_sop/ts_eop/ts_abort 0, grant 0, lost 0.
REQ-029 Reset mid-packet SHALL immediately drop ts_valid; no eop or abort issued.

Structure
REQ-030 PKT_LEN default, SYNC_BYTE 8'h47 and the FSM state encoding SHALL live in a shared ts package used by all TS blocks.
REQ-031 Round-robin next-channel selection SHALL be one sub-module, rr_next4 (inputs mask, last; outputs next, any).

Verification
REQ-032 All enabled, four aligned 188-byte streams -> grants 0,1,2,3,0 in order; each packet 188 ts_valid cycles, sop on 0x47, eop on byte 188.
REQ-033 ch_enable=4'b0101 -> only grants 0 and 2 alternate; channels 2,4 never forwarded.
REQ-034 Channel 2 stuck (no pkt_start), all enabled -> after 400 cycles in WAIT_START, lost=4'b0010, next grant 2; clear_lost pulse -> lost=0.
REQ-035 Granted channel re-syncs at byte 100 -> ts_abort one pulse, no ts_eop, grant advances.
REQ-036 rst low during byte 50 of FORWARD -> ts_valid 0 next edge, all outputs at reset values; after release first grant is channel 1.
REQ-037 ch_enable=0 -> stays SELECT, ts_valid never asserted; enabling bit 3 -> grant 3.

Source files
------------

// File: rtl/ts_pkg.sv
// Shared transport-stream definitions used by every TS block:
// default packet length, the MPEG-TS sync byte and the arbiter FSM encoding.
package ts_pkg;

    localparam int TS_PKT_LEN = 188;

    localparam logic [7:0] SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {
        SELECT     = 2'd0,
        WAIT_START = 2'd1,
        FORWARD    = 2'd2
    } ts_arb_state_t;

endpackage

// File: rtl/ts_packet_arbiter_rr_next4.sv
// Four-way round-robin pointer: picks the first set bit of mask strictly
// after last in cyclic order (last itself is considered only after the
// other three). any is low when mask is empty, in which case next = last.
module rr_next4
    import ts_pkg::*;
(
    input  logic [3:0] mask,
    input  logic [1:0] last,
    output logic [1:0] next,
    output logic       any
);

    logic [1:0] cand;

    // Scan from furthest to nearest so the nearest enabled channel wins
    always_comb begin
        next = last;
        any  = 1'b0;
        cand = last;
        for (int i = 4; i >= 1; i--) begin
            cand = last + 2'(i);
            if (mask[cand]) begin
                next = cand;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ts_packet_arbiter.sv
// Packet-granular round-robin arbiter that shares one TS output among four
// byte streams. Non-granted streams are dropped; a granted channel that never
// produces a sync within TIMEOUT cycles is flagged in the sticky lost vector.
module ts_packet_arbiter
    import ts_pkg::*;
#(
    parameter int PKT_LEN = TS_PKT_LEN,
    parameter int TIMEOUT = 400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ts_in_1,
    input  logic [7:0] ts_in_2,
    input  logic [7:0] ts_in_3,
    input  logic [7:0] ts_in_4,
    input  logic       pkt_start_1,
    input  logic       pkt_start_2,
    input  logic       pkt_start_3,
    input  logic       pkt_start_4,
    input  logic [3:0] ch_enable,
    input  logic       clear_lost,
    output logic [7:0] ts_out,
    output logic       ts_valid,
    output logic       ts_sop,
    output logic       ts_eop,
    output logic       ts_abort,
    output logic [1:0] grant,
    output logic [3:0] lost
);

    localparam int BW = $clog2(PKT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(PKT_LEN);
    localparam logic [BW-1:0] ONE_BYTE  = BW'(1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    ts_arb_state_t state, state_nxt;
    logic [1:0]    last_grant, last_grant_nxt;
    logic [1:0]    grant_nxt;
    logic [BW-1:0] byte_cnt, byte_cnt_nxt, byte_next;
    logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [3:0]    lost_nxt;
    logic          lost_set;

    logic [7:0]    sel_byte;
    logic          sel_start;
    logic [1:0]    rr_next;
    logic          rr_any;

    logic [7:0]    out_byte;
    logic          out_valid, out_sop, out_eop, out_abort;

    rr_next4 u_rr (
        .mask (ch_enable),
        .last (last_grant),
        .next (rr_next),
        .any  (rr_any)
    );

    assign byte_next = byte_cnt + ONE_BYTE;

    // Route the granted channel's byte and sync marker; others are ignored
    always_comb begin
        sel_byte  = ts_in_1;
        sel_start = pkt_start_1;
        case (grant)
            2'd0: begin sel_byte = ts_in_1; sel_start = pkt_start_1; end
            2'd1: begin sel_byte = ts_in_2; sel_start = pkt_start_2; end
            2'd2: begin sel_byte = ts_in_3; sel_start = pkt_start_3; end
            default: begin sel_byte = ts_in_4; sel_start = pkt_start_4; end
        endcase
    end

    // State, grant bookkeeping and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SELECT;
            last_grant <= 2'd3;
            grant      <= 2'd0;
            byte_cnt   <= '0;
            tmo_cnt    <= '0;
            lost       <= 4'b0000;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            grant      <= grant_nxt;
            byte_cnt   <= byte_cnt_nxt;
            tmo_cnt    <= tmo_cnt_nxt;
            lost       <= lost_nxt;
        end
    end

    // Next-state logic; ch_enable only matters before forwarding begins
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        grant_nxt      = grant;
        byte_cnt_nxt   = byte_cnt;
        tmo_cnt_nxt    = tmo_cnt;
        lost_set       = 1'b0;
        case (state)
            SELECT: begin
                byte_cnt_nxt = '0;
                tmo_cnt_nxt  = '0;
                if (rr_any) begin
                    grant_nxt = rr_next;
                    state_nxt = WAIT_START;
                end
            end
            WAIT_START: begin
                if (!ch_enable[grant]) begin
                    last_grant_nxt = grant;
                    tmo_cnt_nxt    = '0;
                    state_nxt      = SELECT;
                end else if (sel_start) begin
                    byte_cnt_nxt = ONE_BYTE;
                    tmo_cnt_nxt  = '0;
                    if (LAST_BYTE == ONE_BYTE) begin
                        last_grant_nxt = grant;
                        state_nxt      = SELECT;
                    end else begin
                        state_nxt = FORWARD;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    lost_set       = 1'b1;
                    last_grant_nxt = grant;
                    tmo_cnt_nxt    = '0;
                    state_nxt      = SELECT;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + TW'(1);
                end
            end
            FORWARD: begin
                if (sel_start) begin
                    last_grant_nxt = grant;
                    byte_cnt_nxt   = '0;
                    state_nxt      = SELECT;
                end else begin
                    byte_cnt_nxt = byte_next;
                    if (byte_next == LAST_BYTE) begin
                        last_grant_nxt = grant;
                        state_nxt      = SELECT;
                    end
                end
            end
            default: begin
                state_nxt = SELECT;
            end
        endcase
        lost_nxt = (clear_lost ? 4'b0000 : lost)
                 | (lost_set ? (4'b0001 << grant) : 4'b0000);
    end

    // Output decode for the byte currently presented on the granted input
    always_comb begin
        out_byte  = 8'h00;
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_abort = 1'b0;
        case (state)
            WAIT_START: begin
                if (ch_enable[grant] && sel_start) begin
                    out_byte  = sel_byte;
                    out_valid = 1'b1;
                    out_sop   = 1'b1;
                    out_eop   = (LAST_BYTE == ONE_BYTE);
                end
            end
            FORWARD: begin
                if (sel_start) begin
                    out_abort = 1'b1;
                end else begin
                    out_byte  = sel_byte;
                    out_valid = 1'b1;
                    out_eop   = (byte_next == LAST_BYTE);
                end
            end
            default: begin
            end
        endcase
    end

    // Register the output so every byte leaves one cycle after it arrived
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_out   <= 8'h00;
            ts_valid <= 1'b0;
            ts_sop   <= 1'b0;
            ts_eop   <= 1'b0;
            ts_abort <= 1'b0;
        end else begin
            ts_out   <= out_byte;
            ts_valid <= out_valid;
            ts_sop   <= out_sop;
            ts_eop   <= out_eop;
            ts_abort <= out_abort;
        end
    end

endmodule
